// File: rtl/psg_bus_sequencer.sv
// psg_bus_sequencer: shares the address latch of a TurboSound YM2149 pair
// between Z80 port strobes and a secondary register-write master. It turns
// both into BDIR/BC phases and puts the CPU's selected register back after
// every secondary write.
module psg_bus_sequencer #(
  parameter bit RESTORE_EN   = 1'b1,
  parameter bit DEFAULT_CHIP = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cpu_addr_wr,
  input  logic       i_cpu_data_wr,
  input  logic       i_cpu_rd,
  input  logic [7:0] i_cpu_di,
  output logic [7:0] o_cpu_do,
  output logic       o_cpu_wait,
  output logic       o_overrun,
  input  logic       i_seq_req,
  input  logic       i_seq_chip,
  input  logic [3:0] i_seq_reg,
  input  logic [7:0] i_seq_data,
  output logic       o_seq_ack,
  output logic [1:0] o_psg_bdir,
  output logic [1:0] o_psg_bc,
  output logic [7:0] o_psg_di,
  input  logic [7:0] i_psg_do0,
  input  logic [7:0] i_psg_do1,
  output logic       o_chip_sel
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU_ADDR,
    ST_CPU_DATA,
    ST_SEQ_ADDR,
    ST_SEQ_DATA,
    ST_SEQ_RESTORE,
    ST_SEQ_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic       r_slotValid, r_slotIsAddr;
  logic [7:0] r_slotData;
  logic       r_overrun, r_chipSel, r_fair, r_seqBlock, r_seqChip;
  logic [7:0] r_shadow0, r_shadow1, r_seqData;
  logic [1:0] r_bdir, r_bc;
  logic [7:0] r_di;
  logic       r_ack, r_wait;

  logic       w_slotValid_nxt, w_slotIsAddr_nxt;
  logic [7:0] w_slotData_nxt;
  logic       w_overrun_nxt, w_chipSel_nxt, w_fair_nxt, w_seqBlock_nxt, w_seqChip_nxt;
  logic [7:0] w_shadow0_nxt, w_shadow1_nxt, w_seqData_nxt;
  logic [1:0] w_bdir_nxt, w_bc_nxt;
  logic [7:0] w_di_nxt;
  logic       w_ack_nxt, w_wait_nxt;

  // CPU work is an ordered list: held slot entry first, then ADDR, then DATA.
  // Only the first can execute; the next fits in the slot; a third is lost.
  logic       w_firstValid, w_firstIsAddr, w_secondValid, w_secondIsAddr, w_thirdValid;
  logic [7:0] w_firstData;
  logic       w_isIdle, w_seqEff, w_grantCpu, w_grantSeq, w_isSelect;
  logic [7:0] w_seqShadow;

  assign w_firstValid   = r_slotValid | i_cpu_addr_wr | i_cpu_data_wr;
  assign w_firstIsAddr  = r_slotValid ? r_slotIsAddr : i_cpu_addr_wr;
  assign w_firstData    = r_slotValid ? r_slotData : i_cpu_di;
  assign w_secondValid  = (r_slotValid & (i_cpu_addr_wr | i_cpu_data_wr)) |
                          (i_cpu_addr_wr & i_cpu_data_wr);
  assign w_secondIsAddr = r_slotValid & i_cpu_addr_wr;
  assign w_thirdValid   = r_slotValid & i_cpu_addr_wr & i_cpu_data_wr;

  assign w_isIdle    = (r_state == ST_IDLE);
  assign w_seqEff    = i_seq_req & ~r_seqBlock;
  assign w_grantCpu  = w_isIdle & w_firstValid & (~w_seqEff | ~r_fair);
  assign w_grantSeq  = w_isIdle & w_seqEff & ~w_grantCpu;
  assign w_isSelect  = w_firstIsAddr & (w_firstData[7:1] == 7'h7F);
  assign w_seqShadow = r_seqChip ? r_shadow1 : r_shadow0;

  // Read data is the only combinational output so the CPU sees it in-cycle.
  assign o_cpu_do = (w_isIdle && i_cpu_rd) ? (r_chipSel ? i_psg_do1 : i_psg_do0) : 8'hFF;

  assign o_cpu_wait = r_wait;
  assign o_overrun  = r_overrun;
  assign o_seq_ack  = r_ack;
  assign o_psg_bdir = r_bdir;
  assign o_psg_bc   = r_bc;
  assign o_psg_di   = r_di;
  assign o_chip_sel = r_chipSel;

  // Next state, slot bookkeeping and the bus phase to present next cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_slotValid_nxt  = w_grantCpu ? w_secondValid  : w_firstValid;
    w_slotIsAddr_nxt = w_grantCpu ? w_secondIsAddr : w_firstIsAddr;
    w_slotData_nxt   = w_grantCpu ? i_cpu_di       : w_firstData;
    w_overrun_nxt    = r_overrun | (w_grantCpu ? w_thirdValid : w_secondValid);
    w_chipSel_nxt    = r_chipSel;
    w_shadow0_nxt    = r_shadow0;
    w_shadow1_nxt    = r_shadow1;
    w_fair_nxt       = r_fair;
    w_seqBlock_nxt   = 1'b0;
    w_seqChip_nxt    = r_seqChip;
    w_seqData_nxt    = r_seqData;
    w_bdir_nxt       = 2'b00;
    w_bc_nxt         = 2'b00;
    w_di_nxt         = 8'h00;
    w_ack_nxt        = 1'b0;
    w_wait_nxt       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_grantCpu) begin
          w_fair_nxt = 1'b1;
          if (w_isSelect) begin
            w_chipSel_nxt = ~w_firstData[0];
          end else if (w_firstIsAddr) begin
            if (r_chipSel) w_shadow1_nxt = w_firstData;
            else           w_shadow0_nxt = w_firstData;
            w_state_nxt           = ST_CPU_ADDR;
            w_bdir_nxt[r_chipSel] = 1'b1;
            w_bc_nxt[r_chipSel]   = 1'b1;
            w_di_nxt              = w_firstData;
          end else begin
            w_state_nxt           = ST_CPU_DATA;
            w_bdir_nxt[r_chipSel] = 1'b1;
            w_di_nxt              = w_firstData;
          end
        end else if (w_grantSeq) begin
          w_fair_nxt             = 1'b0;
          w_seqChip_nxt          = i_seq_chip;
          w_seqData_nxt          = i_seq_data;
          w_state_nxt            = ST_SEQ_ADDR;
          w_bdir_nxt[i_seq_chip] = 1'b1;
          w_bc_nxt[i_seq_chip]   = 1'b1;
          w_di_nxt               = {4'h0, i_seq_reg};
        end
      end
      ST_CPU_ADDR, ST_CPU_DATA: begin
        w_state_nxt = ST_IDLE;
      end
      ST_SEQ_ADDR: begin
        w_state_nxt           = ST_SEQ_DATA;
        w_bdir_nxt[r_seqChip] = 1'b1;
        w_di_nxt              = r_seqData;
      end
      ST_SEQ_DATA: begin
        if (RESTORE_EN) begin
          w_state_nxt           = ST_SEQ_RESTORE;
          w_bdir_nxt[r_seqChip] = 1'b1;
          w_bc_nxt[r_seqChip]   = 1'b1;
          w_di_nxt              = w_seqShadow;
        end else begin
          w_state_nxt = ST_SEQ_DONE;
          w_ack_nxt   = 1'b1;
        end
      end
      ST_SEQ_RESTORE: begin
        w_state_nxt = ST_SEQ_DONE;
        w_ack_nxt   = 1'b1;
      end
      ST_SEQ_DONE: begin
        w_state_nxt    = ST_IDLE;
        w_seqBlock_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_state_nxt == ST_IDLE && i_cpu_rd) w_bc_nxt[w_chipSel_nxt] = 1'b1;
    w_wait_nxt = w_slotValid_nxt | (i_cpu_rd & (w_state_nxt != ST_IDLE));
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Registered outputs, pending slot, shadow addresses and arbitration flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slotValid  <= 1'b0;
      r_slotIsAddr <= 1'b0;
      r_slotData   <= 8'h00;
      r_overrun    <= 1'b0;
      r_chipSel    <= DEFAULT_CHIP;
      r_shadow0    <= 8'h00;
      r_shadow1    <= 8'h00;
      r_fair       <= 1'b0;
      r_seqBlock   <= 1'b0;
      r_seqChip    <= 1'b0;
      r_seqData    <= 8'h00;
      r_bdir       <= 2'b00;
      r_bc         <= 2'b00;
      r_di         <= 8'h00;
      r_ack        <= 1'b0;
      r_wait       <= 1'b0;
    end else begin
      r_slotValid  <= w_slotValid_nxt;
      r_slotIsAddr <= w_slotIsAddr_nxt;
      r_slotData   <= w_slotData_nxt;
      r_overrun    <= w_overrun_nxt;
      r_chipSel    <= w_chipSel_nxt;
      r_shadow0    <= w_shadow0_nxt;
      r_shadow1    <= w_shadow1_nxt;
      r_fair       <= w_fair_nxt;
      r_seqBlock   <= w_seqBlock_nxt;
      r_seqChip    <= w_seqChip_nxt;
      r_seqData    <= w_seqData_nxt;
      r_bdir       <= w_bdir_nxt;
      r_bc         <= w_bc_nxt;
      r_di         <= w_di_nxt;
      r_ack        <= w_ack_nxt;
      r_wait       <= w_wait_nxt;
    end
  end

endmodule
